fcvt_issue: RTL and testbench



---
 rtl/fcvt_issue.sv | 153 +++++++++++++++
 tb/tb_fcvt_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_issue.sv
// fcvt_issue
// Registered issue stage in front of the combinational integer-to-float
// converter. Each accepted operation is conditioned on its way in: the operand
// is sign- or zero-extended for its opcode, and the exception hints are
// precomputed. It then waits in a 2-entry FIFO, and the converter always sees
// the head entry straight from registers.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             drop every buffered op and any push offered this cycle
//   in_valid/in_ready upstream handshake; in_ready ignores out_ready
//   in_data           raw integer register value
//   in_op             00=W, 01=WU, 10=L, 11=LU (bit 1 ignored when BUS_WIDTH=32)
//   in_tag            destination register tag
//   out_valid/out_ready  head handshake toward converter/writeback
//   out_operand       conditioned two's-complement operand
//   out_tag           tag of the head entry
//   out_inexact       magnitude spans more bits than mantissa+1
//   out_unsigned_ovf  unsigned operand with MSB set
//   out_count         occupancy 0..2
module fcvt_issue #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic [1:0]           in_op,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_operand,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_inexact,
  output logic                 out_unsigned_ovf,
  output logic [1:0]           out_count
);

  localparam int MANT  = (BUS_WIDTH == 64) ? 52 : 23;
  localparam int IDX_W = $clog2(BUS_WIDTH);

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] operand;
    logic [TAG_WIDTH-1:0] tag;
    logic                 inexact;
    logic                 unsigned_ovf;
  } entry_t;

  state_t               state, state_nxt;
  entry_t               entries [2];
  entry_t               new_entry;
  logic                 wr_ptr, rd_ptr;
  logic                 push, pop;

  logic                 op_long, op_unsigned;
  logic [BUS_WIDTH-1:0] cond, mag;
  logic [IDX_W-1:0]     hi_idx, lo_idx;

  // Enqueue-side conditioning and exception-hint precomputation.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    op_long     = (BUS_WIDTH == 64) && in_op[1];
    op_unsigned = in_op[0];

    if (op_long)          cond = in_data;
    else if (op_unsigned) cond = BUS_WIDTH'(in_data[31:0]);
    else                  cond = BUS_WIDTH'($signed(in_data[31:0]));

    // Negating the most negative value yields 2^(BUS_WIDTH-1) unchanged,
    // which is exactly the magnitude wanted: one set bit, hence exact.
    mag = (!op_unsigned && cond[BUS_WIDTH-1]) ? -cond : cond;

    hi_idx = '0;
    lo_idx = '0;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      if (mag[i]) hi_idx = IDX_W'(i);
    end
    for (int i = BUS_WIDTH - 1; i >= 0; i--) begin
      if (mag[i]) lo_idx = IDX_W'(i);
    end

    new_entry.operand      = cond;
    new_entry.tag          = in_tag;
    new_entry.unsigned_ovf = op_unsigned && cond[BUS_WIDTH-1];
    new_entry.inexact      = (mag != '0) && ((hi_idx - lo_idx) > IDX_W'(MANT));
  end

  // in_ready is deliberately independent of out_ready: no pop-then-push
  // bypass when FULL keeps the upstream handshake free of converter timing.
  assign in_ready  = !rst && !flush && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_count = state;

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Head fields come straight from entry registers through the read-pointer
  // mux, so nothing on in_* reaches out_* combinationally.
  assign out_operand      = entries[rd_ptr].operand;
  assign out_tag          = entries[rd_ptr].tag;
  assign out_inexact      = entries[rd_ptr].inexact;
  assign out_unsigned_ovf = entries[rd_ptr].unsigned_ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: the entry storage is reset because the head outputs read it
      // directly and must show zeros after reset; flush leaves it alone.
      for (int i = 0; i < 2; i++) entries[i] <= '0;
    end else if (flush) begin
      // Flush beats a same-cycle pop; a same-cycle push is already blocked
      // by in_ready.
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        entries[wr_ptr] <= new_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_fcvt_issue.sv
// Scoreboard bench for fcvt_issue. One instance is 64-bit and one is 32-bit.
// The stimulus pushes hand-computed expectations for each accepted op. Per-
// instance monitors pop and compare them whenever the head is consumed.
module tb_fcvt_issue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64;
  logic [63:0] in_data64, out_operand64;
  logic [1:0]  in_op64, out_count64;
  logic [4:0]  in_tag64, out_tag64;
  logic        out_inexact64, out_ovf64;

  logic        flush32, in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_data32, out_operand32;
  logic [1:0]  in_op32, out_count32;
  logic [4:0]  in_tag32, out_tag32;
  logic        out_inexact32, out_ovf32;

  fcvt_issue #(.BUS_WIDTH(64), .TAG_WIDTH(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_data(in_data64),
    .in_op(in_op64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .out_operand(out_operand64), .out_tag(out_tag64),
    .out_inexact(out_inexact64), .out_unsigned_ovf(out_ovf64),
    .out_count(out_count64)
  );

  fcvt_issue #(.BUS_WIDTH(32), .TAG_WIDTH(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32),
    .in_op(in_op32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_operand(out_operand32), .out_tag(out_tag32),
    .out_inexact(out_inexact32), .out_unsigned_ovf(out_ovf32),
    .out_count(out_count32)
  );

  typedef struct {
    logic [63:0] operand;
    logic [4:0]  tag;
    logic        inexact;
    logic        ovf;
  } exp_t;

  exp_t sb64[$];
  exp_t sb32[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [1:0] OP_W = 2'b00, OP_WU = 2'b01, OP_L = 2'b10, OP_LU = 2'b11;

  function automatic exp_t mk(input logic [63:0] operand, input logic [4:0] tag,
                              input logic inexact, input logic ovf);
    exp_t e;
    e.operand = operand;
    e.tag     = tag;
    e.inexact = inexact;
    e.ovf     = ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitors: compare whenever the converter consumes the head.
  always @(negedge clk) begin : mon64
    exp_t e;
    if (!rst && out_valid64 && out_ready64) begin
      if (sb64.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut64_unexpected_output actual_tag=%0d expected=none", out_tag64);
      end else begin
        e = sb64.pop_front();
        check("dut64_operand", out_operand64, e.operand);
        check("dut64_tag", 64'(out_tag64), 64'(e.tag));
        check("dut64_inexact", 64'(out_inexact64), 64'(e.inexact));
        check("dut64_unsigned_ovf", 64'(out_ovf64), 64'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin : mon32
    exp_t e;
    if (!rst && out_valid32 && out_ready32) begin
      if (sb32.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut32_unexpected_output actual_tag=%0d expected=none", out_tag32);
      end else begin
        e = sb32.pop_front();
        check("dut32_operand", 64'(out_operand32), e.operand);
        check("dut32_tag", 64'(out_tag32), 64'(e.tag));
        check("dut32_inexact", 64'(out_inexact32), 64'(e.inexact));
        check("dut32_unsigned_ovf", 64'(out_ovf32), 64'(e.ovf));
      end
    end
  end

  // One clock of stimulus on the selected instance (sel=0: 64-bit, 1: 32-bit).
  // exp_rdy is the hand-derived in_ready for this cycle; an op is expected to
  // be accepted only when it is offered and exp_rdy is 1.
  task automatic step(input bit sel, input bit v, input logic [1:0] op,
                      input logic [63:0] d, input logic [4:0] tag,
                      input bit ordy, input bit fl, input bit exp_rdy, input exp_t e);
    if (!sel) begin
      in_valid64 = v; in_op64 = op; in_data64 = d; in_tag64 = tag;
      out_ready64 = ordy; flush64 = fl;
    end else begin
      in_valid32 = v; in_op32 = op; in_data32 = d[31:0]; in_tag32 = tag;
      out_ready32 = ordy; flush32 = fl;
    end
    @(negedge clk);
    if (!sel) begin
      check("dut64_in_ready", 64'(in_ready64), 64'(exp_rdy));
      if (v && exp_rdy) sb64.push_back(e);
    end else begin
      check("dut32_in_ready", 64'(in_ready32), 64'(exp_rdy));
      if (v && exp_rdy) sb32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      if (!sel) sb64.delete();
      else      sb32.delete();
    end
    if (!sel) begin in_valid64 = 1'b0; flush64 = 1'b0; end
    else      begin in_valid32 = 1'b0; flush32 = 1'b0; end
  endtask

  // Streaming step on the 64-bit instance with out_ready high; occupancy must hold at 1.
  task automatic stream64(input logic [1:0] op, input logic [63:0] d, input logic [4:0] tag, input exp_t e);
    step(1'b0, 1'b1, op, d, tag, 1'b1, 1'b0, 1'b1, e);
    check("dut64_stream_count", 64'(out_count64), 64'd1);
    check("dut64_stream_valid", 64'(out_valid64), 64'd1);
  endtask

  task automatic stream32(input logic [1:0] op, input logic [31:0] d, input logic [4:0] tag, input exp_t e);
    step(1'b1, 1'b1, op, 64'(d), tag, 1'b1, 1'b0, 1'b1, e);
    check("dut32_stream_count", 64'(out_count32), 64'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "time limit exceeded");
  end

  initial begin : stim
    exp_t nil;
    nil = mk(64'd0, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; in_data64 = '0; in_op64 = '0; in_tag64 = '0; out_ready64 = 1'b0;
    flush32 = 1'b0; in_valid32 = 1'b0; in_data32 = '0; in_op32 = '0; in_tag32 = '0; out_ready32 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready64", 64'(in_ready64), 64'd0);
    check("rst_in_ready32", 64'(in_ready32), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    check("rst_count64", 64'(out_count64), 64'd0);
    check("rst_operand64", out_operand64, 64'd0);
    check("rst_tag64", 64'(out_tag64), 64'd0);
    check("rst_inexact64", 64'(out_inexact64), 64'd0);
    check("rst_ovf64", 64'(out_ovf64), 64'd0);
    check("rst_out_valid32", 64'(out_valid32), 64'd0);
    check("rst_count32", 64'(out_count32), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // W sign-extends the low word: 0xFFFFFFFF -> -1, one cycle latency.
    step(1'b0, 1'b1, OP_W, 64'h0000_0000_FFFF_FFFF, 5'd3, 1'b0, 1'b0, 1'b1,
         mk(64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1'b0, 1'b0));
    check("w_count", 64'(out_count64), 64'd1);
    check("w_valid", 64'(out_valid64), 64'd1);
    check("w_head_operand", out_operand64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("w_head_tag", 64'(out_tag64), 64'd3);

    // Streaming tags 0..7 with out_ready high: one op in, one op out per cycle.
    stream64(OP_LU, 64'h8000_0000_0000_0001, 5'd0, mk(64'h8000_0000_0000_0001, 5'd0, 1'b1, 1'b1));
    stream64(OP_L,  64'h8000_0000_0000_0000, 5'd1, mk(64'h8000_0000_0000_0000, 5'd1, 1'b0, 1'b0));
    stream64(OP_WU, 64'hDEAD_BEEF_8000_0000, 5'd2, mk(64'h0000_0000_8000_0000, 5'd2, 1'b0, 1'b0));
    stream64(OP_L,  64'h0020_0000_0000_0001, 5'd3, mk(64'h0020_0000_0000_0001, 5'd3, 1'b1, 1'b0));
    stream64(OP_L,  64'h0010_0000_0000_0001, 5'd4, mk(64'h0010_0000_0000_0001, 5'd4, 1'b0, 1'b0));
    stream64(OP_W,  64'h1234_5678_8000_0001, 5'd5, mk(64'hFFFF_FFFF_8000_0001, 5'd5, 1'b0, 1'b0));
    stream64(OP_L,  64'hFFDF_FFFF_FFFF_FFFF, 5'd6, mk(64'hFFDF_FFFF_FFFF_FFFF, 5'd6, 1'b1, 1'b0));
    stream64(OP_LU, 64'h7FFF_FFFF_FFFF_FFFF, 5'd7, mk(64'h7FFF_FFFF_FFFF_FFFF, 5'd7, 1'b1, 1'b0));
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    check("stream_drain_count", 64'(out_count64), 64'd0);

    // Backpressure: two accepted, third refused, head stable, order kept.
    step(1'b0, 1'b1, OP_L, 64'd1, 5'd1, 1'b0, 1'b0, 1'b1, mk(64'd1, 5'd1, 1'b0, 1'b0));
    step(1'b0, 1'b1, OP_L, 64'd2, 5'd2, 1'b0, 1'b0, 1'b1, mk(64'd2, 5'd2, 1'b0, 1'b0));
    check("bp_full_count", 64'(out_count64), 64'd2);
    step(1'b0, 1'b1, OP_L, 64'd3, 5'd3, 1'b0, 1'b0, 1'b0, nil);
    check("bp_head_stable_tag", 64'(out_tag64), 64'd1);
    check("bp_still_full", 64'(out_count64), 64'd2);
    step(1'b0, 1'b1, OP_L, 64'd3, 5'd3, 1'b1, 1'b0, 1'b0, nil);
    check("bp_after_pop_count", 64'(out_count64), 64'd1);
    check("bp_after_pop_tag", 64'(out_tag64), 64'd2);
    step(1'b0, 1'b1, OP_L, 64'd3, 5'd3, 1'b1, 1'b0, 1'b1, mk(64'd3, 5'd3, 1'b0, 1'b0));
    check("bp_swap_count", 64'(out_count64), 64'd1);
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    check("bp_drain_count", 64'(out_count64), 64'd0);

    // Flush while full, with push and pop offered in the same cycle.
    step(1'b0, 1'b1, OP_L, 64'd11, 5'd11, 1'b0, 1'b0, 1'b1, mk(64'd11, 5'd11, 1'b0, 1'b0));
    step(1'b0, 1'b1, OP_L, 64'd12, 5'd12, 1'b0, 1'b0, 1'b1, mk(64'd12, 5'd12, 1'b0, 1'b0));
    check("fl_full_count", 64'(out_count64), 64'd2);
    step(1'b0, 1'b1, OP_L, 64'd13, 5'd13, 1'b1, 1'b1, 1'b0, nil);
    check("fl_count", 64'(out_count64), 64'd0);
    check("fl_valid", 64'(out_valid64), 64'd0);
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    step(1'b0, 1'b1, OP_L, 64'd14, 5'd14, 1'b0, 1'b0, 1'b1, mk(64'd14, 5'd14, 1'b0, 1'b0));
    check("fl_recover_tag", 64'(out_tag64), 64'd14);
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    check("fl_recover_drain", 64'(out_count64), 64'd0);

    // Reset mid-operation behaves like a flush and restores reset outputs.
    step(1'b0, 1'b1, OP_L, 64'h55, 5'd15, 1'b0, 1'b0, 1'b1, nil);
    sb64.delete();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready64), 64'd0);
    @(posedge clk);
    #1;
    check("midrst_valid", 64'(out_valid64), 64'd0);
    check("midrst_count", 64'(out_count64), 64'd0);
    check("midrst_operand", out_operand64, 64'd0);
    check("midrst_tag", 64'(out_tag64), 64'd0);
    rst = 1'b0;
    step(1'b0, 1'b0, OP_L, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);

    // 32-bit instance: L/LU fold onto W/WU, mantissa is 23 bits.
    stream32(OP_L,  32'h8000_0000, 5'd1, mk(64'h8000_0000, 5'd1, 1'b0, 1'b0));
    stream32(OP_LU, 32'h8000_0001, 5'd2, mk(64'h8000_0001, 5'd2, 1'b1, 1'b1));
    stream32(OP_W,  32'h0100_0001, 5'd3, mk(64'h0100_0001, 5'd3, 1'b1, 1'b0));
    stream32(OP_W,  32'h0080_0001, 5'd4, mk(64'h0080_0001, 5'd4, 1'b0, 1'b0));
    stream32(OP_WU, 32'hFFFF_FFFF, 5'd5, mk(64'hFFFF_FFFF, 5'd5, 1'b1, 1'b1));
    stream32(OP_W,  32'hFFFF_FFFF, 5'd6, mk(64'hFFFF_FFFF, 5'd6, 1'b0, 1'b0));
    step(1'b1, 1'b0, OP_W, 64'd0, 5'd0, 1'b1, 1'b0, 1'b1, nil);
    check("dut32_drain_count", 64'(out_count32), 64'd0);

    check("sb64_drained", 64'(sb64.size()), 64'd0);
    check("sb32_drained", 64'(sb32.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
